cache_nway: RTL and testbench
=============================

CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning number of ways per set; legal values 2, 4, 8.
REQ-002 SHALL have parameter INDEX_BITS, default 3, meaning set-index width, giving 2**INDEX_BITS sets; legal range 1..8.
REQ-003 SHALL derive fixed geometry: 16-byte line (offset = mem_address[3:0]), index = mem_address[3+INDEX_BITS:4], tag width TAG_BITS = 12-INDEX_BITS.
REQ-004 SHALL have ports, one per line:
 clk  in  1  sole clock, all state updates on rising edge
 reset  in  1  asynchronous, active-high reset
 mem_address  in  16  CPU byte address (lc3b_word)
 mem_read  in  1  CPU read request
 mem_write  in  1  CPU write request
 mem_byte_enable  in  2  byte lanes of mem_wdata to write
 mem_wdata  in  16  CPU write data
 mem_rdata  out  16  CPU read data
 mem_resp  out  1  one-cycle request completion
 pmem_address  out  16  line-aligned physical address
 pmem_rdata  in  128  line fill data (lc3b_data)
 pmem_wdata  out  128  writeback line data
 pmem_read  out  1  line fill request
 pmem_write  out  1  line writeback request
 pmem_resp  in  1  physical memory completion
 hit_count  out  16  hits since reset
 miss_count  out  16  misses since reset

Function
REQ-005 SHALL implement a WAYS-way set-associative, write-back, write-allocate cache with per-way data, tag, valid and dirty arrays and per-set tree pseudo-LRU of WAYS-1 bits.
REQ-006 SHALL contain FSM states IDLE, WRITEBACK, ALLOCATE; reset state IDLE.
REQ-007 In IDLE with a request, hit = some way valid with matching tag; at most one way may hit.
REQ-008 On read hit SHALL assert mem_resp combinationally in the same cycle, mem_rdata = word offset[3:1] of the hit line; latency 1 cycle.
REQ-009 On write hit SHALL assert mem_resp same cycle and, at the clock edge, write only enabled byte lanes (bit0 = low byte) of word offset[3:1] and set that way's dirty bit.
REQ-010 On any hit SHALL update PLRU so every tree node on the accessed way's path points away from it, and increment hit_count.
REQ-011 On miss in IDLE SHALL latch victim: lowest-numbered invalid way if any, else the PLRU-indicated way; increment miss_count once per miss.
REQ-012 Miss with dirty valid victim: IDLE -> WRITEBACK; else IDLE -> ALLOCATE.
REQ-013 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata=victim line; on pmem_resp -> ALLOCATE.
REQ-014 ALLOCATE: pmem_read=1, pmem_address={req tag, index, 4'b0}; on pmem_resp write pmem_rdata, tag, valid=1, dirty=0 into victim way, -> IDLE.
REQ-015 After ALLOCATE the held request SHALL complete as a hit in IDLE the following cycle (miss latency = fill cycles + writeback cycles + 1).
REQ-016 mem_resp SHALL be low outside IDLE; pmem_read and pmem_write SHALL never both be high.
REQ-017 Requester holds address/data/controls stable until mem_resp; mem_read and mem_write both high SHALL be treated as a write.
REQ-018 hit_count and miss_count SHALL wrap from 16'hFFFF to 0.
REQ-019 pmem_address SHALL equal {mem_address[15:4], 4'b0} in IDLE.

Reset
REQ-020 Reset assertion SHALL immediately force IDLE, clear all valid, dirty and PLRU bits and both counters, and drive mem_resp, pmem_read, pmem_write low, including mid-WRITEBACK/ALLOCATE; data and tag arrays are not reset.
REQ-021 A pmem_resp arriving during or after an aborted transfer while in IDLE SHALL be ignored.

Verification
REQ-022 After reset, read 16'h0042 -> miss, ALLOCATE with pmem_address 16'h0040, fill; next cycle mem_resp=1, mem_rdata = word 1 of fill; miss_count=1.
REQ-023 Write 16'hBEEF, byte_enable 2'b10 to 16'h0042 after fill -> same-cycle mem_resp; readback high byte BE, low byte unchanged; hit_count=2.
REQ-024 WAYS=2: fill 16'h0040, 16'h0840 (same set), touch 16'h0040, read 16'h1040 -> victim way holding 16'h0840; no writeback if clean.
REQ-025 Dirty victim -> pmem_write with pmem_address of old tag and modified line, then pmem_read of new line, mem_resp only after both.
REQ-026 Assert reset during ALLOCATE -> pmem_read drops same cycle, all lookups miss, counters 0.
REQ-027 WAYS=4 regression: four fills in one set then fifth miss evicts the PLRU way; 65536 hits wrap hit_count to 0.

Source files
------------

// File: rtl/cache_nway.sv
// cache_nway: WAYS-way set-associative, write-back, write-allocate cache
// with 16-byte lines and a per-set tree pseudo-LRU.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   mem_address/read/write/byte_enable/wdata  CPU request (held until mem_resp)
//   mem_rdata, mem_resp CPU read data and one-cycle completion
//   pmem_address/rdata/wdata/read/write/resp  line-wide physical memory port
//   hit_count, miss_count  wrapping 16-bit event counters
//
// Address split: [3:0] byte offset, [3+INDEX_BITS:4] set index,
// [15:4+INDEX_BITS] tag.
module cache_nway #(
  parameter int WAYS       = 2,
  parameter int INDEX_BITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  input  logic [127:0]  pmem_rdata,
  output logic [127:0]  pmem_wdata,
  output logic          pmem_read,
  output logic          pmem_write,
  input  logic          pmem_resp,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);

  localparam int SETS     = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 12 - INDEX_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e                state_q;
  logic [WAY_BITS-1:0]   victim_q;
  logic [127:0]          data_q  [WAYS][SETS];
  logic [TAG_BITS-1:0]   tag_q   [WAYS][SETS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-2:0]       plru_q  [SETS];
  logic [15:0]           hit_q;
  logic [15:0]           miss_q;

  // Tree PLRU: nodes in heap order (children of n are 2n+1, 2n+2).
  // A node bit of 0 points the victim search left, 1 points it right.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-2:0] t);
    logic [WAY_BITS-1:0] w;
    logic [WAY_BITS-1:0] n;
    w = '0;
    n = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      w[WAY_BITS-1-l] = t[n];
      n = (n << 1) + WAY_BITS'(1) + WAY_BITS'(t[n]);
    end
    return w;
  endfunction

  // Every node on the accessed way's path is set to point away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [WAY_BITS-1:0] w);
    logic [WAYS-2:0]     r;
    logic [WAY_BITS-1:0] n;
    logic                d;
    r = t;
    n = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      d    = w[WAY_BITS-1-l];
      r[n] = ~d;
      n    = (n << 1) + WAY_BITS'(1) + WAY_BITS'(d);
    end
    return r;
  endfunction

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [6:0]            word_base;
  logic                  req;
  logic                  is_write;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [WAY_BITS-1:0]   victim_d;
  logic [127:0]          hit_line;
  logic [127:0]          merged_line;
  logic                  unused_addr_bit;

  assign idx             = mem_address[3+INDEX_BITS:4];
  assign req_tag         = mem_address[15:4+INDEX_BITS];
  assign word_base       = {mem_address[3:1], 4'b0000};
  assign unused_addr_bit = mem_address[0];
  assign req             = mem_read | mem_write;
  // Read and write together is handled as a write.
  assign is_write        = mem_write;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[w][idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins (descending scan, last match sticks);
  // otherwise the PLRU choice.
  always_comb begin
    victim_d = plru_victim(plru_q[idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim_d = WAY_BITS'(w);
    end
  end

  assign hit_line = data_q[hit_way][idx];

  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < 2; b++) begin
      if (mem_byte_enable[b]) merged_line[int'(word_base) + 8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              hit_q       <= hit_q + 16'd1;
              plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
              if (is_write) dirty_q[idx][hit_way] <= 1'b1;
            end else begin
              miss_q   <= miss_q + 16'd1;
              victim_q <= victim_d;
              state_q  <= (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) ? WRITEBACK
                                                                               : ALLOCATE;
            end
          end
        end
        WRITEBACK: if (pmem_resp) state_q <= ALLOCATE;
        ALLOCATE: begin
          if (pmem_resp) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            state_q                <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: data and tag arrays are deliberately not reset; the valid bits
  // alone decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req && hit && is_write) data_q[hit_way][idx] <= merged_line;
    if (state_q == ALLOCATE && pmem_resp) begin
      data_q[victim_q][idx] <= pmem_rdata;
      tag_q[victim_q][idx]  <= req_tag;
    end
  end

  // Outputs decode the registered state, so an asynchronous reset drops
  // pmem_read/pmem_write/mem_resp immediately.
  assign mem_resp     = (state_q == IDLE) && req && hit;
  assign mem_rdata    = hit_line[int'(word_base) +: 16];
  assign pmem_read    = (state_q == ALLOCATE);
  assign pmem_write   = (state_q == WRITEBACK);
  assign pmem_address = (state_q == WRITEBACK) ? {tag_q[victim_q][idx], idx, 4'b0000}
                                               : {mem_address[15:4], 4'b0000};
  assign pmem_wdata   = data_q[victim_q][idx];
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_cache_nway.sv
module tb_cache_nway;

  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_wdata = '0;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic         sel = 1'b0;  // 0: WAYS=2 instance, 1: WAYS=4 instance

  logic [15:0]  a_rdata, b_rdata, a_paddr, b_paddr, a_hits, b_hits, a_miss, b_miss;
  logic [127:0] a_pwdata, b_pwdata;
  logic         a_resp, b_resp, a_pread, b_pread, a_pwrite, b_pwrite;
  logic         a_presp, b_presp;

  assign a_presp = pmem_resp & ~sel;
  assign b_presp = pmem_resp & sel;

  cache_nway #(.WAYS(2), .INDEX_BITS(3)) dut2 (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(a_rdata), .mem_resp(a_resp), .pmem_address(a_paddr), .pmem_rdata(pmem_rdata),
    .pmem_wdata(a_pwdata), .pmem_read(a_pread), .pmem_write(a_pwrite), .pmem_resp(a_presp),
    .hit_count(a_hits), .miss_count(a_miss)
  );

  cache_nway #(.WAYS(4), .INDEX_BITS(3)) dut4 (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(b_rdata), .mem_resp(b_resp), .pmem_address(b_paddr), .pmem_rdata(pmem_rdata),
    .pmem_wdata(b_pwdata), .pmem_read(b_pread), .pmem_write(b_pwrite), .pmem_resp(b_presp),
    .hit_count(b_hits), .miss_count(b_miss)
  );

  logic [15:0]  mem_rdata, pmem_address, hit_count, miss_count;
  logic [127:0] pmem_wdata;
  logic         mem_resp, pmem_read, pmem_write;
  assign mem_rdata    = sel ? b_rdata  : a_rdata;
  assign mem_resp     = sel ? b_resp   : a_resp;
  assign pmem_address = sel ? b_paddr  : a_paddr;
  assign pmem_wdata   = sel ? b_pwdata : a_pwdata;
  assign pmem_read    = sel ? b_pread  : a_pread;
  assign pmem_write   = sel ? b_pwrite : a_pwrite;
  assign hit_count    = sel ? b_hits   : a_hits;
  assign miss_count   = sel ? b_miss   : a_miss;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Backing store: written lines are remembered, others follow a pattern.
  logic [127:0] bmem [logic [15:0]];
  logic [15:0]  wb_addr, rd_addr;
  logic [127:0] wb_data;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        miss;
    logic        wb;
    logic [15:0] wb_addr;
    logic [15:0] rdata;
  } vec_t;

  vec_t tab2 [14];
  vec_t tab4 [10];
  vec_t tabr [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    if (bmem.exists(a)) return bmem[a];
    for (int k = 0; k < 8; k++) l[16*k +: 16] = {a[15:4], 4'(k)} ^ 16'hA500;
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Drives one request and services the pmem port until mem_resp.
  task automatic run_vec(input string tag, input int i, input vec_t v);
    int lat, wait_cnt, wb_lat, rd_lat, wbn, rdn;
    logic done, bad_proto, bad_idle_addr;
    logic [15:0] rdat;
    lat = 0; wait_cnt = 0; wb_lat = -1; rd_lat = -1; wbn = 0; rdn = 0;
    done = 1'b0; bad_proto = 1'b0; bad_idle_addr = 1'b0; rdat = '0;
    mem_address = v.addr; mem_read = v.rd; mem_write = v.wr;
    mem_byte_enable = v.be; mem_wdata = v.wd;
    while (!done && lat < 200) begin
      #1;
      lat++;
      if (pmem_read && pmem_write) bad_proto = 1'b1;
      if (lat == 1 && pmem_address !== {v.addr[15:4], 4'b0000}) bad_idle_addr = 1'b1;
      if (mem_resp) begin
        rdat = mem_rdata;
        done = 1'b1;
        if (pmem_read || pmem_write) bad_proto = 1'b1;
      end else if (pmem_read || pmem_write) begin
        wait_cnt++;
        if (wait_cnt == MEM_LAT) begin
          wait_cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            bmem[pmem_address] = pmem_wdata;
            wbn++; wb_lat = lat; wb_addr = pmem_address; wb_data = pmem_wdata;
          end else begin
            pmem_rdata = line_of(pmem_address);
            rdn++; rd_lat = lat; rd_addr = pmem_address;
          end
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    exp_hits++;
    if (v.miss) exp_misses++;
    check($sformatf("%s[%0d] completed", tag, i), done, 1'b1);
    check($sformatf("%s[%0d] protocol", tag, i), bad_proto, 1'b0);
    check($sformatf("%s[%0d] idle pmem_address", tag, i), bad_idle_addr, 1'b0);
    if (!v.miss) begin
      check($sformatf("%s[%0d] hit latency", tag, i), lat, 1);
    end else begin
      check($sformatf("%s[%0d] fill count", tag, i), rdn, 1);
      check($sformatf("%s[%0d] fill address", tag, i), rd_addr, {v.addr[15:4], 4'b0000});
      check($sformatf("%s[%0d] resp after fill", tag, i), lat - rd_lat, 1);
    end
    check($sformatf("%s[%0d] writeback count", tag, i), wbn, v.wb ? 1 : 0);
    if (v.wb) begin
      check($sformatf("%s[%0d] writeback address", tag, i), wb_addr, v.wb_addr);
      check($sformatf("%s[%0d] writeback before fill", tag, i), wb_lat < rd_lat, 1'b1);
    end
    if (v.rd && !v.wr) check($sformatf("%s[%0d] rdata", tag, i), rdat, v.rdata);
    check($sformatf("%s[%0d] hit_count", tag, i), hit_count, 16'(exp_hits));
    check($sformatf("%s[%0d] miss_count", tag, i), miss_count, 16'(exp_misses));
  endtask

  initial begin
    logic seen;
    //          addr      rd wr be     wd        miss wb wb_addr   rdata
    tab2[0]  = '{16'h0042, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hA541};
    tab2[1]  = '{16'h0042, 0, 1, 2'b10, 16'hBEEF, 0, 0, 16'h0000, 16'h0000};
    tab2[2]  = '{16'h0042, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hBE41};
    tab2[3]  = '{16'h004E, 0, 1, 2'b01, 16'h1234, 0, 0, 16'h0000, 16'h0000};
    tab2[4]  = '{16'h0046, 1, 1, 2'b11, 16'hCAFE, 0, 0, 16'h0000, 16'h0000};
    tab2[5]  = '{16'h0046, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hCAFE};
    tab2[6]  = '{16'h004E, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hA534};
    tab2[7]  = '{16'h0846, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hAD43};
    tab2[8]  = '{16'h0040, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hA540};
    tab2[9]  = '{16'h1040, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hB540};
    tab2[10] = '{16'h0042, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hBE41};
    tab2[11] = '{16'h0840, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hAD40};
    tab2[12] = '{16'h1040, 1, 0, 2'b00, 16'h0000, 1, 1, 16'h0040, 16'hB540};
    tab2[13] = '{16'h0042, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hBE41};

    tabr[0]  = '{16'h0042, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hBE41};
    tabr[1]  = '{16'h1040, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hB540};

    tab4[0]  = '{16'h0040, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hA540};
    tab4[1]  = '{16'h0840, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hAD40};
    tab4[2]  = '{16'h1040, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hB540};
    tab4[3]  = '{16'h1840, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hBD40};
    tab4[4]  = '{16'h0040, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hA540};
    tab4[5]  = '{16'h2040, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'h8540};
    tab4[6]  = '{16'h0040, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hA540};
    tab4[7]  = '{16'h0840, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hAD40};
    tab4[8]  = '{16'h1840, 1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'hBD40};
    tab4[9]  = '{16'h1040, 1, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 16'hB540};

    // Reset state, two-way instance.
    sel = 1'b0;
    do_reset();
    mem_address = 16'h1234;
    #1;
    check("reset mem_resp", mem_resp, 1'b0);
    check("reset pmem_read", pmem_read, 1'b0);
    check("reset pmem_write", pmem_write, 1'b0);
    check("reset hit_count", hit_count, 16'h0);
    check("reset miss_count", miss_count, 16'h0);
    check("idle pmem_address", pmem_address, 16'h1230);

    for (int i = 0; i < 14; i++) run_vec("w2", i, tab2[i]);
    check("dirty line word1", wb_data[31:16], 16'hBE41);
    check("dirty line word3", wb_data[63:48], 16'hCAFE);
    check("dirty line word7", wb_data[127:112], 16'hA534);

    // Reset in the middle of ALLOCATE, then a stale pmem_resp in IDLE.
    mem_address = 16'h3040;
    mem_read = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("allocate reached", seen, 1'b1);
    reset = 1'b1;
    #1;
    check("abort pmem_read", pmem_read, 1'b0);
    check("abort pmem_write", pmem_write, 1'b0);
    check("abort mem_resp", mem_resp, 1'b0);
    check("abort hit_count", hit_count, 16'h0);
    check("abort miss_count", miss_count, 16'h0);
    @(negedge clk);
    mem_read = 1'b0;
    reset = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    pmem_resp = 1'b1;
    pmem_rdata = '1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("stale resp pmem_read", pmem_read, 1'b0);
    check("stale resp pmem_write", pmem_write, 1'b0);
    check("stale resp miss_count", miss_count, 16'h0);
    for (int i = 0; i < 2; i++) run_vec("rst", i, tabr[i]);

    // Four-way instance: PLRU victim choice and counter wrap.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) run_vec("w4", i, tab4[i]);

    do_reset();
    run_vec("wrap", 0, tab4[0]);
    mem_address = 16'h0040;
    mem_read = 1'b1;
    repeat (65534) @(negedge clk);
    check("hit_count at max", hit_count, 16'hFFFF);
    @(negedge clk);
    mem_read = 1'b0;
    check("hit_count wrapped", hit_count, 16'h0000);
    check("miss_count after wrap", miss_count, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
